load_store_unit: RTL and testbench

//  Sequencer between the CPU execute stage and the byte-addressable 64-bit RAM. Accepts one

---
 rtl/lsu_pkg.sv | 17 +
 rtl/load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes (common with the RAM size port)
// and FSM state values.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load extension: keeps the low 8<<size bits and fills the rest with
// zero or the kept field's MSB. Zero latency, no flow control.
module load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [63:0] result_o
);

    always_comb begin
        result_o = data_i;
        case (size_i)
            SIZE_B:  result_o = {{56{signed_i & data_i[7]}},  data_i[7:0]};
            SIZE_H:  result_o = {{48{signed_i & data_i[15]}}, data_i[15:0]};
            SIZE_W:  result_o = {{32{signed_i & data_i[31]}}, data_i[31:0]};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer in front of a 64-bit RAM with registered reads.
// Store resp 2 cycles after accept, load 3; holds the response indefinitely while resp_ready is low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [63:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [63:0]           mem_data,
    output logic                  mem_chip_select,
    output logic                  mem_write_enable,
    output logic                  mem_output_enable,
    output logic [1:0]            mem_size
);

    lsu_state_e            state_q;
    logic                  write_q;
    logic                  signed_q;
    logic [63:0]           wdata_q;
    logic                  drive_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [1:0]            size_q;
    logic                  cs_q;
    logic                  we_q;
    logic                  oe_q;
    logic                  resp_valid_q;
    logic [63:0]           resp_rdata_q;
    logic [63:0]           load_ext;

    load_extend u_load_extend (
        .data_i   (mem_data),
        .size_i   (size_q),
        .signed_i (signed_q),
        .result_o (load_ext)
    );

    // drive_q is only ever set for the single ACCESS cycle of a store, while oe_q is low
    assign mem_data          = drive_q ? wdata_q : 64'bz;
    assign req_ready         = (state_q == ST_IDLE);
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign mem_address       = address_q;
    assign mem_size          = size_q;
    assign mem_chip_select   = cs_q;
    assign mem_write_enable  = we_q;
    assign mem_output_enable = oe_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            drive_q      <= 1'b0;
            address_q    <= '0;
            size_q       <= SIZE_B;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata;
                        address_q <= req_address;
                        size_q    <= req_size;
                        cs_q      <= 1'b1;
                        we_q      <= req_write;
                        oe_q      <= ~req_write;
                        drive_q   <= req_write;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (write_q) begin
                        cs_q         <= 1'b0;
                        we_q         <= 1'b0;
                        drive_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        state_q      <= ST_RESP;
                    end else begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cs_q         <= 1'b0;
                    oe_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_ext;
                    state_q      <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural little-endian 64-bit RAM
// with one-cycle registered reads and 8-bit address wrap.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_address = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic [7:0]  mem_address;
    wire  [63:0] mem_data;
    logic        mem_chip_select;
    logic        mem_write_enable;
    logic        mem_output_enable;
    logic [1:0]  mem_size;

    int nchecks = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clock             (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_size          (req_size),
        .req_signed        (req_signed),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_chip_select   (mem_chip_select),
        .mem_write_enable  (mem_write_enable),
        .mem_output_enable (mem_output_enable),
        .mem_size          (mem_size)
    );

    // RAM model
    logic [7:0]  ram [0:255];
    logic [63:0] ram_rd_q = '0;
    logic        ram_oe;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    end

    assign ram_oe   = mem_chip_select & mem_output_enable & ~mem_write_enable;
    assign mem_data = ram_oe ? ram_rd_q : 64'bz;

    always @(posedge clk) begin
        if (mem_chip_select && mem_write_enable) begin
            for (int k = 0; k < 8; k++)
                if (k < (1 << mem_size)) ram[mem_address + 8'(k)] <= mem_data[8*k +: 8];
        end
        if (ram_oe) begin
            for (int k = 0; k < 8; k++) ram_rd_q[8*k +: 8] <= ram[mem_address + 8'(k)];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor: no contention, and read data is known in the capture cycle
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("bus_contention", 64'(mem_chip_select & mem_write_enable & mem_output_enable), 64'd0);
            if (ram_oe && prev_rd)
                chk("capture_no_x", 64'($isunknown(mem_data)), 64'd0);
        end
        prev_rd = ram_oe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [7:0] a, input logic [1:0] sz,
                          input logic sg, input logic [63:0] wd, input int exp_lat,
                          input logic [63:0] exp_rd, input string tag);
        int n;
        req_write   = w;
        req_address = a;
        req_size    = sz;
        req_signed  = sg;
        req_wdata   = wd;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        tick();
    endtask

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_strobes", 64'({mem_chip_select, mem_write_enable, mem_output_enable}), 64'd0);
        chk("rst_addr_size", 64'({mem_address, mem_size}), 64'd0);

        // Aligned 64-bit store/load and narrow extensions
        do_req(1'b1, 8'h00, 2'b11, 1'b0, 64'h0123456789ABCDEF, 2, 64'd0, "st64");
        do_req(1'b0, 8'h00, 2'b11, 1'b0, 64'd0, 3, 64'h0123456789ABCDEF, "ld64");
        do_req(1'b0, 8'h01, 2'b00, 1'b1, 64'd0, 3, 64'hFFFFFFFFFFFFFFCD, "ld8s");
        do_req(1'b0, 8'h01, 2'b00, 1'b0, 64'd0, 3, 64'h00000000000000CD, "ld8u");
        do_req(1'b0, 8'h06, 2'b01, 1'b1, 64'd0, 3, 64'h0000000000000123, "ld16s");

        // Misaligned word store spanning the 8-byte boundary
        do_req(1'b1, 8'h06, 2'b10, 1'b0, 64'h00000000DEADBEEF, 2, 64'd0, "st32");
        do_req(1'b0, 8'h06, 2'b10, 1'b1, 64'd0, 3, 64'hFFFFFFFFDEADBEEF, "ld32s");
        do_req(1'b0, 8'h00, 2'b11, 1'b0, 64'd0, 3, 64'hBEEF456789ABCDEF, "ld64_merge");
        do_req(1'b0, 8'h08, 2'b01, 1'b1, 64'd0, 3, 64'hFFFFFFFFFFFFDEAD, "ld16s_neg");
        do_req(1'b0, 8'h06, 2'b10, 1'b0, 64'd0, 3, 64'h00000000DEADBEEF, "ld32u");

        // Backpressure with a second request waiting
        resp_ready  = 1'b0;
        req_write   = 1'b0;
        req_address = 8'h01;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_valid   = 1'b1;
        tick();
        req_address = 8'h02;
        tick();
        tick();
        chk("bp_enter_valid", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_resp_rdata", resp_rdata, 64'h00000000000000CD);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_strobes", 64'({mem_chip_select, mem_write_enable, mem_output_enable}), 64'd0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_after_hs_valid", 64'(resp_valid), 64'd0);
        chk("bp_after_hs_ready", 64'(req_ready), 64'd1);
        tick();
        chk("bp_second_accepted", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_second_latency", 64'(n), 64'd3);
        chk("bp_second_rdata", resp_rdata, 64'h00000000000000AB);
        tick();

        // Reset during CAPTURE
        req_write   = 1'b0;
        req_address = 8'h00;
        req_size    = 2'b11;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rc_access_oe", 64'({mem_chip_select, mem_output_enable}), 64'd3);
        tick();
        chk("rc_capture_oe", 64'({mem_chip_select, mem_output_enable}), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rc_req_ready", 64'(req_ready), 64'd1);
        chk("rc_resp_valid", 64'(resp_valid), 64'd0);
        chk("rc_strobes", 64'({mem_chip_select, mem_write_enable, mem_output_enable}), 64'd0);
        chk("rc_addr_rdata", resp_rdata | 64'(mem_address), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rc_no_resp", 64'(resp_valid), 64'd0);
        end

        // Address wrap at the top of memory
        do_req(1'b1, 8'hFF, 2'b01, 1'b0, 64'h0000000000008001, 2, 64'd0, "st16_wrap");
        do_req(1'b0, 8'hFF, 2'b01, 1'b0, 64'd0, 3, 64'h0000000000008001, "ld16_wrap");
        do_req(1'b0, 8'h00, 2'b00, 1'b1, 64'd0, 3, 64'hFFFFFFFFFFFFFF80, "ld8_wrapped_byte");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
